// File: rtl/sonar_shift_reg_ctl.sv
// sonar_shift_reg_ctl
// Parametrised load/shift register with a counted serial mode. A parallel word
// is loaded, then exactly WIDTH bits are shifted out through serial_out while
// serial_in is captured at the vacated end. busy, done and shift_count let the
// downstream sequencers hand words off without counting bits themselves.
// Optional running parity of the shifted-in bits: define SHREG_PARITY_EN.
module sonar_shift_reg_ctl #(
  parameter int WIDTH     = 14,
  parameter int CNT_W     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_count,
  output logic             parity
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Count value present while the final shift of a word is being performed.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_q_shifted;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_done;
  logic             w_done_next;

  // Shift direction and outgoing bit are fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_q_shifted = {r_q[WIDTH-2:0], serial_in};
      assign serial_out  = r_q[WIDTH-1];
    end else begin : g_lsb_first
      assign w_q_shifted = {serial_in, r_q[WIDTH-1:1]};
      assign serial_out  = r_q[0];
    end
  endgenerate

  // State register; enable freezes the sequence in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else if (enable) begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath decode; done defaults low so it lasts one enabled cycle.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A simultaneous load+start shifts the freshly loaded word.
        if (load) begin
          w_q_next = d;
        end
        if (start) begin
          w_count_next = '0;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // load/start are deliberately ignored until the word is finished.
        w_q_next     = w_q_shifted;
        w_count_next = r_count + CNT_W'(1);
        if (r_count == LAST_CNT) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Data, count and done registers, all gated by the clock enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (enable) begin
      r_q     <= w_q_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
    end
  end

`ifdef SHREG_PARITY_EN
  logic r_parity;
  logic w_parity_next;

  // Parity restarts with each sequence and accumulates every captured bit.
  always_comb begin
    w_parity_next = r_parity;
    if (r_state == ST_IDLE) begin
      if (start) begin
        w_parity_next = 1'b0;
      end
    end else begin
      w_parity_next = r_parity ^ serial_in;
    end
  end

  // Parity register; holds its final value through IDLE until the next start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_parity <= 1'b0;
    end else if (enable) begin
      r_parity <= w_parity_next;
    end
  end

  assign parity = r_parity;
`else
  assign parity = 1'b0;
`endif

  assign q           = r_q;
  assign busy        = (r_state == ST_SHIFT);
  assign done        = r_done;
  assign shift_count = r_count;

endmodule

// File: tb/tb_sonar_shift_reg_ctl.sv
// tb_sonar_shift_reg_ctl
// Drives one MSB-first and one LSB-first instance with identical stimulus and
// compares both against a word-level reference model every clock. Parity
// expectations follow SHREG_PARITY_EN.
module tb_sonar_shift_reg_ctl;

  localparam int W = 14;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  d = '0;
  logic          serial_in = 1'b0;

  logic          so0, so1;
  logic [W-1:0]  q0, q1;
  logic          busy0, busy1, done0, done1, par0, par1;
  logic [4:0]    cnt0, cnt1;

  logic [22:0]   obs0, obs1;
  assign obs0 = {q0, so0, busy0, done0, cnt0, par0};
  assign obs1 = {q1, so1, busy1, done1, cnt1, par1};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, one entry per instance (0 = MSB first, 1 = LSB first).
  int unsigned m_q[2];
  int          m_cnt[2];
  bit          m_busy[2];
  bit          m_done[2];
  bit          m_par[2];

  always #5 clk = ~clk;

  sonar_shift_reg_ctl #(.WIDTH(W), .CNT_W(5), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .resetn(resetn), .enable(enable), .load(load), .start(start),
    .d(d), .serial_in(serial_in), .serial_out(so0), .q(q0), .busy(busy0),
    .done(done0), .shift_count(cnt0), .parity(par0)
  );

  sonar_shift_reg_ctl #(.WIDTH(W), .CNT_W(5), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .resetn(resetn), .enable(enable), .load(load), .start(start),
    .d(d), .serial_in(serial_in), .serial_out(so1), .q(q1), .busy(busy1),
    .done(done1), .shift_count(cnt1), .parity(par1)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_par[k] = 0;
    end
  endtask

  // One enabled clock edge applied to the word-level model.
  task automatic model_edge();
    if (!resetn || !enable) return;
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k]) begin
        m_done[k] = 0;
        if (load) m_q[k] = d;
        if (start) begin
          m_cnt[k] = 0; m_par[k] = 0; m_busy[k] = 1;
        end
      end else begin
        if (k == 0) m_q[k] = (m_q[k] * 2 + serial_in) % (1 << W);
        else        m_q[k] = m_q[k] / 2 + serial_in * (1 << (W - 1));
        m_cnt[k] = m_cnt[k] + 1;
        m_par[k] = m_par[k] ^ serial_in;
        if (m_cnt[k] == W) begin
          m_busy[k] = 0; m_done[k] = 1;
        end
      end
    end
  endtask

  function automatic logic [22:0] exp_vec(int k);
    logic [W-1:0] mq;
    logic         so;
    logic         par;
    mq = W'(m_q[k]);
    so = (k == 0) ? mq[W-1] : mq[0];
`ifdef SHREG_PARITY_EN
    par = m_par[k];
`else
    par = 1'b0;
`endif
    return {mq, so, m_busy[k], m_done[k], 5'(m_cnt[k]), par};
  endfunction

  // Apply inputs away from the edge, clock once, advance the model.
  task automatic cycle(bit en, bit ld, bit st, logic [W-1:0] dd, bit sin);
    @(negedge clk);
    enable = en; load = ld; start = st; d = dd; serial_in = sin;
    @(posedge clk);
    model_edge();
    #1;
    if (en && m_done[0])
      $display("word complete: msb q=%h lsb q=%h count=%0d", q0, q1, cnt0);
  endtask

  task automatic test_reset();
    resetn = 0; enable = 1; load = 1; start = 1; d = 14'h3ABC; serial_in = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL reset dut0: got %h expected %h", obs0, exp_vec(0)); end
    n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL reset dut1: got %h expected %h", obs1, exp_vec(1)); end
    n_cmp++; if (q0 !== 14'h0000) begin n_bad++; $display("FAIL reset_q: got %h expected 0000", q0); end
    @(negedge clk);
    load = 0; start = 0; resetn = 1;
    $display("reset released");
  endtask

  task automatic test_msb_directed();
    logic [W-1:0] seq = 14'h2A5C;
    int busy_n = 0;
    int done_n = 0;
    cycle(1, 1, 0, 14'h2A5C, 0);
    n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL msb_load dut0: got %h expected %h", obs0, exp_vec(0)); end
    n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL msb_load dut1: got %h expected %h", obs1, exp_vec(1)); end
    n_cmp++; if ({q0, so0, busy0, done0} !== {14'h2A5C, 3'b100}) begin n_bad++; $display("FAIL msb_load_direct: got %h/%b%b%b expected 2a5c/100", q0, so0, busy0, done0); end
    cycle(1, 0, 1, 14'h0000, 1);
    for (int i = 0; i < W; i++) begin
      n_cmp++; if (so0 !== seq[W-1-i]) begin n_bad++; $display("FAIL msb_serial_bit%0d: got %b expected %b", i, so0, seq[W-1-i]); end
      busy_n += int'(busy0);
      cycle(1, 0, 0, 14'h0000, 1);
      done_n += int'(done0);
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL msb_shift dut0: got %h expected %h", obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL msb_shift dut1: got %h expected %h", obs1, exp_vec(1)); end
    end
    n_cmp++; if ({q0, cnt0, done0, busy0} !== {14'h3FFF, 5'd14, 2'b10}) begin n_bad++; $display("FAIL msb_final: got %h/%0d/%b%b expected 3fff/14/10", q0, cnt0, done0, busy0); end
`ifdef SHREG_PARITY_EN
    n_cmp++; if (par0 !== 1'b0) begin n_bad++; $display("FAIL msb_parity: got %b expected 0", par0); end
`endif
    cycle(1, 0, 0, 14'h0000, 1);
    done_n += int'(done0);
    n_cmp++; if (busy_n !== 14) begin n_bad++; $display("FAIL msb_busy_cycles: got %0d expected 14", busy_n); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL msb_done_pulses: got %0d expected 1", done_n); end
  endtask

  task automatic test_lsb_load_start();
    int done_n = 0;
    cycle(1, 1, 1, 14'h0001, 0);
    n_cmp++; if (so1 !== 1'b1) begin n_bad++; $display("FAIL lsb_first_bit: got %b expected 1", so1); end
    for (int i = 0; i < W + 1; i++) begin
      cycle(1, 0, 0, 14'h0000, 0);
      done_n += int'(done1);
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL lsb_shift dut0: got %h expected %h", obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL lsb_shift dut1: got %h expected %h", obs1, exp_vec(1)); end
    end
    n_cmp++; if (q1 !== 14'h0000) begin n_bad++; $display("FAIL lsb_final_q: got %h expected 0000", q1); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL lsb_done_pulses: got %0d expected 1", done_n); end
  endtask

  task automatic test_enable_hold();
    int done_at = 0;
    cycle(1, 1, 1, 14'($urandom), 1'($urandom));
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 14'h0000, 1'($urandom));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 14'h0000, 1'($urandom));
      n_cmp++; if (cnt0 !== 5'd5) begin n_bad++; $display("FAIL hold_count: got %0d expected 5", cnt0); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL hold dut1: got %h expected %h", obs1, exp_vec(1)); end
    end
    for (int i = 1; i <= 12; i++) begin
      cycle(1, i == 1, 0, 14'h1234, 1'($urandom));
      if (done0 && done_at == 0) done_at = i;
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL hold_resume dut0: got %h expected %h", obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL hold_resume dut1: got %h expected %h", obs1, exp_vec(1)); end
    end
    n_cmp++; if (done_at !== 9) begin n_bad++; $display("FAIL hold_done_latency: got %0d expected 9", done_at); end
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    cycle(1, 1, 1, 14'($urandom), 1'($urandom));
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 14'h0000, 1'($urandom));
    @(negedge clk);
    #2 resetn = 0;
    #1;
    n_cmp++; if ({q0, busy0, cnt0, done0} !== 21'd0) begin n_bad++; $display("FAIL async_reset dut0: got %h/%b/%0d/%b expected 0/0/0/0", q0, busy0, cnt0, done0); end
    n_cmp++; if ({q1, busy1, cnt1, done1} !== 21'd0) begin n_bad++; $display("FAIL async_reset dut1: got %h/%b/%0d/%b expected 0/0/0/0", q1, busy1, cnt1, done1); end
    model_reset();
    @(negedge clk);
    resetn = 1;
    cycle(1, 0, 1, 14'h0000, 1'($urandom));
    for (int i = 0; i < W; i++) begin
      cycle(1, 0, 0, 14'h0000, 1'($urandom));
      done_n += int'(done0);
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL post_reset dut0: got %h expected %h", obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL post_reset dut1: got %h expected %h", obs1, exp_vec(1)); end
    end
    n_cmp++; if ({done_n, cnt0} !== {32'd1, 5'd14}) begin n_bad++; $display("FAIL post_reset_full: got done=%0d count=%0d expected done=1 count=14", done_n, cnt0); end
  endtask

  task automatic test_back_to_back();
    cycle(1, 1, 1, 14'($urandom), 1'($urandom));
    for (int i = 0; i < W; i++) cycle(1, 0, 0, 14'h0000, 1'($urandom));
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b expected 1", done0); end
    cycle(1, 1, 1, 14'($urandom), 1'($urandom));
    n_cmp++; if ({busy0, done0, cnt0} !== 7'b10_00000) begin n_bad++; $display("FAIL b2b_restart: got busy=%b done=%b count=%0d expected 1/0/0", busy0, done0, cnt0); end
    for (int i = 0; i < W; i++) begin
      cycle(1, 0, 0, 14'h0000, 1'($urandom));
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL b2b dut0: got %h expected %h", obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL b2b dut1: got %h expected %h", obs1, exp_vec(1)); end
    end
    n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done: got %b expected 1", done1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
            14'($urandom), 1'($urandom));
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL random%0d dut0: got %h expected %h", i, obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL random%0d dut1: got %h expected %h", i, obs1, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_directed();
    test_lsb_load_start();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sonar_shift_reg_ctl.md
Name: sonar_shift_reg_ctl

Overview:
- Parametrised shift register with a controlled serial mode, the general-width successor of the fixed 14-bit muxed-input shift registers in the SONAR path.
- Parallel-loads a WIDTH-bit word, then shifts exactly WIDTH bits on command through serial_out while capturing serial_in.
- A bit counter, busy flag and one-cycle done pulse let the ADC/serial sequencers hand off words without external counting.

Parameters:
- WIDTH, 14, register and word width in bits (>= 2).
- CNT_W, 5, shift counter width; must satisfy 2**CNT_W > WIDTH.
- MSB_FIRST, 1, 1 = shift toward MSB (serial_in enters bit 0, serial_out = q[WIDTH-1]); 0 = shift toward LSB (serial_in enters bit WIDTH-1, serial_out = q[0]).

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  clock enable; when low, all state holds (including done).
- load  input  1  parallel-load request.
- start  input  1  begin a WIDTH-bit shift sequence.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  serial data shifted in.
- serial_out  output  1  current outgoing bit, combinational from q.
- q  output  WIDTH  register contents.
- busy  output  1  high while in SHIFT.
- done  output  1  one-enabled-cycle pulse after the final shift.
- shift_count  output  CNT_W  number of shifts completed in the current sequence.
- parity  output  1  running parity of bits shifted in (see Optional Feature).

Behaviour:
- Reset (resetn low, asynchronous): q = 0, state = IDLE, busy = 0, done = 0, shift_count = 0, parity = 0. Reset mid-sequence aborts it; no done pulse.
- All register updates occur on rising clk only when enable = 1. With enable = 0, everything holds, including a pending done.
- States:
  - IDLE:
    - load=1, start=0: q <= d; stay IDLE.
    - start=1, load=0: shift_count <= 0; parity <= 0; go SHIFT.
    - load=1, start=1: q <= d, shift_count <= 0, parity <= 0, go SHIFT; the loaded word is the one shifted.
  - SHIFT:
    - Each enabled edge: q shifts one position per MSB_FIRST; serial_in enters at the vacated end; shift_count increments; parity ^= serial_in.
    - load and start are ignored while in SHIFT.
    - On the edge performing shift number WIDTH: shift_count = WIDTH, state -> IDLE, done = 1.
- done is high for exactly one enabled cycle after the final shift and clears on the next enabled edge. load/start are accepted on that same edge (back-to-back words allowed).
- busy = (state == SHIFT). Latency from start to done is WIDTH+1 enabled edges; busy is high for WIDTH enabled cycles.
- shift_count holds its final value (WIDTH) in IDLE until the next start.
- serial_out reflects q immediately after load, before any shift.

Optional Feature:
- Macro SHREG_PARITY_EN.
- Defined: parity is a register updated as above, valid when done = 1 and held until the next start.
- Undefined: no parity logic is generated; the parity port is tied to 0.

Test Plan:
- WIDTH=14, MSB_FIRST=1, reset released, enable=1, load with d=14'h2A5C -> q=14'h2A5C, serial_out=1, busy=0, done=0.
- After the previous step, pulse start with serial_in held 1 -> serial_out sequence 1,0,1,0,1,0,0,1,0,1,1,1,0,0; busy high for 14 cycles; done pulses once on cycle 15; q=14'h3FFF; shift_count=14; parity=0 (14 ones, with SHREG_PARITY_EN).
- load=1 and start=1 together with d=14'h0001, MSB_FIRST=0, serial_in=0 -> first serial_out=1; after 14 shifts q=0 and done pulses once.
- During SHIFT after 5 shifts, drop enable for 3 cycles, then assert load with d=14'h1234 -> shift_count holds at 5 while enable is low; load ignored; done occurs exactly 9 enabled cycles after enable returns.
- Assert resetn low after 7 shifts -> q=0, busy=0, shift_count=0 immediately (asynchronous); no done pulse; a new start afterwards runs a full 14 shifts.
- Assert start on the cycle done is high -> a new sequence begins without an idle gap; busy=1 on the following cycle.
